piso_serializer: RTL and testbench

Parallel-in/serial-out transmitter that serializes WIDTH-bit words onto a single wire, MSB-first or LSB-first. It is the transmit-side counterpart to the team's serial-in/parallel-out shift register. It takes words over a valid/ready handshake and drives one bit per `en` tick, which is typically a baud or bit-rate strobe. A `done` pulse marks the end of each word. Back-to-back words stream without gaps.

---
 rtl/piso_serializer.sv | 89 ++++++++
 tb/tb_piso_serializer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: accepts WIDTH-bit words over valid/ready
// and shifts them out one bit per en tick, MSB- or LSB-first, gapless when streaming.
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             dir,
  input  logic             en,
  output logic             dout,
  output logic             dout_valid,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] sreg, sreg_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             dir_q, dir_d;
  logic             done_d;
  logic             last_edge;

  // The last-bit edge doubles as a reload slot so streamed words leave no gap.
  assign last_edge  = (state == SHIFT) && en && (cnt == LAST);
  assign s_ready    = rst_n && ((state == IDLE) || last_edge);
  assign dout_valid = rst_n && (state == SHIFT);
  assign dout       = dout_valid && (dir_q ? sreg[0] : sreg[WIDTH-1]);

  always_comb begin
    state_d = state;
    sreg_d  = sreg;
    cnt_d   = cnt;
    dir_d   = dir_q;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (s_valid) begin
          sreg_d  = s_data;
          dir_d   = dir;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (en) begin
          if (cnt == LAST) begin
            done_d = 1'b1;
            if (s_valid) begin
              sreg_d = s_data;
              dir_d  = dir;
              cnt_d  = '0;
            end else begin
              sreg_d  = '0;
              state_d = IDLE;
            end
          end else begin
            sreg_d = dir_q ? {1'b0, sreg[WIDTH-1:1]} : {sreg[WIDTH-2:0], 1'b0};
            cnt_d  = cnt + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      dir_q <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      sreg  <= sreg_d;
      cnt   <= cnt_d;
      dir_q <= dir_d;
      done  <= done_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer (WIDTH=8): directed scenarios plus a
// randomized run whose received bit stream is rebuilt into words and compared.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic       dir = 1'b0;
  logic       en = 1'b0;
  logic       dout;
  logic       dout_valid;
  logic       done;

  int checks = 0;
  int failures = 0;

  piso_serializer #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .dir(dir), .en(en), .dout(dout), .dout_valid(dout_valid), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 0; s_valid = 1; s_data = 8'hAA; en = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      checks++;
      if (s_ready !== 1'b0 || dout !== 1'b0 || dout_valid !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_hold got ready=%b dout=%b dv=%b done=%b exp all 0",
                 s_ready, dout, dout_valid, done);
      end
    end
    step();
    rst_n = 1; s_valid = 0; en = 0;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_release_ready got=%b exp=1", s_ready);
    end
    step();
  endtask

  task automatic test_msb_first;
    logic [7:0] w;
    w = 8'hD2;
    dir = 0; s_data = w; s_valid = 1; en = 1;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL msb_ready got=%b exp=1", s_ready);
    end
    step();
    s_valid = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (dout !== w[7-i] || dout_valid !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("[TB] FAIL msb_bit%0d got dout=%b dv=%b done=%b exp dout=%b dv=1 done=0",
                 i, dout, dout_valid, done, w[7-i]);
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || dout_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL msb_done got done=%b dv=%b exp done=1 dv=0", done, dout_valid);
    end
    en = 0;
    step();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL msb_done_pulse got=%b exp=0", done);
    end
  endtask

  task automatic test_lsb_slow;
    logic [7:0] w;
    w = 8'hD2;
    dir = 1; s_data = w; s_valid = 1; en = 0;
    step();
    s_valid = 0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 3; j++) begin
        en = (j == 2);
        dir = $urandom_range(0, 1);
        #1;
        checks++;
        if (dout !== w[i] || dout_valid !== 1'b1) begin
          failures++;
          $display("[TB] FAIL lsb_bit%0d_c%0d got dout=%b dv=%b exp dout=%b dv=1",
                   i, j, dout, dout_valid, w[i]);
        end
        step();
      end
    end
    en = 0;
    checks++;
    if (done !== 1'b1 || dout_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL lsb_done got done=%b dv=%b exp done=1 dv=0", done, dout_valid);
    end
    step();
  endtask

  task automatic test_streaming;
    logic [7:0] w;
    dir = 0; s_data = 8'h81; s_valid = 1; en = 1;
    step();
    s_data = 8'h7E;
    for (int i = 0; i < 16; i++) begin
      s_valid = (i < 8);
      w = (i < 8) ? 8'h81 : 8'h7E;
      #1;
      checks++;
      if (dout !== w[7-(i%8)] || dout_valid !== 1'b1 || s_ready !== (i == 7 || i == 15) ||
          done !== (i == 8)) begin
        failures++;
        $display("[TB] FAIL stream_bit%0d got dout=%b dv=%b rdy=%b done=%b exp dout=%b dv=1 rdy=%b done=%b",
                 i, dout, dout_valid, s_ready, done, w[7-(i%8)], (i == 7 || i == 15), (i == 8));
      end
      step();
    end
    en = 0;
    checks++;
    if (done !== 1'b1 || dout_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stream_done got done=%b dv=%b exp done=1 dv=0", done, dout_valid);
    end
    step();
  endtask

  task automatic test_midframe_reset;
    logic [7:0] w;
    dir = 0; s_data = 8'hFF; s_valid = 1; en = 1;
    step();
    s_valid = 0;
    for (int i = 0; i < 3; i++) step();
    rst_n = 0;
    #1;
    checks++;
    if (s_ready !== 1'b0 || dout !== 1'b0 || dout_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midrst_low got rdy=%b dout=%b dv=%b exp all 0", s_ready, dout, dout_valid);
    end
    step();
    rst_n = 1;
    #1;
    checks++;
    if (dout_valid !== 1'b0 || dout !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midrst_after got dout=%b dv=%b done=%b exp all 0", dout, dout_valid, done);
    end
    w = 8'h01;
    s_data = w; s_valid = 1;
    step();
    s_valid = 0;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midrst_no_done got=%b exp=0", done);
    end
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (dout !== w[7-i] || dout_valid !== 1'b1) begin
        failures++;
        $display("[TB] FAIL midrst_bit%0d got dout=%b dv=%b exp dout=%b dv=1", i, dout, dout_valid, w[7-i]);
      end
      step();
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midrst_done got=%b exp=1", done);
    end
    en = 0;
    step();
  endtask

  task automatic test_stall;
    logic [7:0] a, b;
    a = 8'hA5; b = 8'h3C;
    dir = 0; s_data = a; s_valid = 1; en = 1;
    step();
    s_valid = 0;
    for (int i = 0; i < 3; i++) step();
    en = 0;
    for (int c = 0; c < 10; c++) begin
      if (c >= 2) begin
        s_valid = 1; s_data = b;
      end
      #1;
      checks++;
      if (dout !== a[4] || dout_valid !== 1'b1 || s_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL stall_c%0d got dout=%b dv=%b rdy=%b exp dout=%b dv=1 rdy=0",
                 c, dout, dout_valid, s_ready, a[4]);
      end
      step();
    end
    en = 1;
    for (int i = 3; i < 8; i++) begin
      #1;
      checks++;
      if (dout !== a[7-i] || s_ready !== (i == 7)) begin
        failures++;
        $display("[TB] FAIL stall_bit%0d got dout=%b rdy=%b exp dout=%b rdy=%b",
                 i, dout, s_ready, a[7-i], (i == 7));
      end
      step();
    end
    s_valid = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (dout !== b[7-i] || dout_valid !== 1'b1 || done !== (i == 0)) begin
        failures++;
        $display("[TB] FAIL stall_word2_bit%0d got dout=%b dv=%b done=%b exp dout=%b dv=1 done=%b",
                 i, dout, dout_valid, done, b[7-i], (i == 0));
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || dout_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stall_done got done=%b dv=%b exp done=1 dv=0", done, dout_valid);
    end
    en = 0;
    step();
  endtask

  // Words are offered with random gaps/ticks; every consumed bit is logged and
  // regrouped into words according to the direction each word was sent with.
  task automatic test_random;
    logic [7:0] words[$];
    logic       dirs[$];
    logic       got[$];
    logic [7:0] r;
    int nacc, ndone, cyc;
    nacc = 0; ndone = 0; cyc = 0;
    for (int j = 0; j < 20; j++) begin
      words.push_back(8'($urandom));
      dirs.push_back(1'($urandom));
    end
    s_valid = 0; en = 0;
    while ((nacc < 20 || dout_valid) && cyc < 5000) begin
      en = ($urandom_range(0, 3) != 0);
      if (nacc < 20) begin
        if (!s_valid) s_valid = ($urandom_range(0, 2) == 0);
      end else begin
        s_valid = 0;
      end
      if (s_valid) begin
        s_data = words[nacc]; dir = dirs[nacc];
      end else begin
        s_data = 8'($urandom); dir = 1'($urandom);
      end
      #1;
      if (s_valid && s_ready) nacc++;
      if (dout_valid && en) got.push_back(dout);
      step();
      if (done) ndone++;
      cyc++;
    end
    s_valid = 0; en = 0;
    checks++;
    if (cyc >= 5000) begin
      failures++;
      $display("[TB] FAIL rand_timeout got cycles=%0d exp <5000", cyc);
    end
    checks++;
    if (got.size() != 160 || ndone != 20) begin
      failures++;
      $display("[TB] FAIL rand_counts got bits=%0d dones=%0d exp bits=160 dones=20", got.size(), ndone);
    end
    for (int j = 0; j < 20; j++) begin
      if (got.size() >= 8 * (j + 1)) begin
        r = 8'h00;
        for (int k = 0; k < 8; k++) begin
          if (dirs[j]) r[k] = got[8*j+k];
          else         r[7-k] = got[8*j+k];
        end
        checks++;
        if (r !== words[j]) begin
          failures++;
          $display("[TB] FAIL rand_word%0d got=%02h exp=%02h", j, r, words[j]);
        end
      end
    end
    step();
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_slow();
    test_streaming();
    test_midframe_reset();
    test_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout got time=%0t exp completion", $time);
    $fatal(1, "[TB] timeout");
  end

endmodule
